// File: rtl/skein_subkey_scheduler_pkg.sv
// Shared constants, state encoding and index helpers for the Threefish-1024 subkey scheduler.
// SKEIN_SUBKEY_AUTOINC_EN enables the sk_next_i auto-increment request path.
package skein_pkg;

    localparam int unsigned NUM_WORDS       = 16;
    localparam int unsigned NUM_KEY_WORDS   = 17;
    localparam int unsigned NUM_TWEAK_WORDS = 3;
    localparam int unsigned MAX_SUBKEY      = 20;

    localparam logic [4:0]  MAX_SUBKEY_IDX  = 5'(MAX_SUBKEY);
    localparam logic [63:0] C240            = 64'h1BD1_1BDA_A9FC_1A22;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_KEY,
        ST_LOAD_TWEAK,
        ST_READY,
        ST_GEN
    } state_t;

    // Tweak word used by word 13 (s mod 3) and word 14 ((s+1) mod 3), indexed by s mod 3
    localparam logic [1:0] TWEAK_LUT_LO [NUM_TWEAK_WORDS] = '{2'd0, 2'd1, 2'd2};
    localparam logic [1:0] TWEAK_LUT_HI [NUM_TWEAK_WORDS] = '{2'd1, 2'd2, 2'd0};

    function automatic logic [1:0] mod3_idx(input logic [4:0] v);
        logic [4:0] r;
        r = v;
        if (r >= 5'd12) r = r - 5'd12;
        if (r >= 5'd6)  r = r - 5'd6;
        if (r >= 5'd3)  r = r - 5'd3;
        return r[1:0];
    endfunction

    // s + i never exceeds 35, so at most two conditional subtractions are needed
    function automatic logic [4:0] mod17_idx(input logic [5:0] v);
        if (v >= 6'd34)      return 5'(v - 6'd34);
        else if (v >= 6'd17) return 5'(v - 6'd17);
        else                 return v[4:0];
    endfunction

endpackage

// File: rtl/skein_subkey_scheduler_if.sv
// Key/tweak load stream and subkey register write bus of the subkey scheduler.
// SKEIN_SUBKEY_AUTOINC_EN adds the sk_next_i request line.
interface skein_subkey_scheduler_if;

    logic        load_start_i;
    logic        in_valid_i;
    logic [63:0] in_word_i;
    logic        in_ready_o;
    logic        sk_req_i;
    logic [4:0]  sk_idx_i;
`ifdef SKEIN_SUBKEY_AUTOINC_EN
    logic        sk_next_i;
`endif
    logic [15:0] sk_we_o;
    logic [63:0] sk_word_o;
    logic        sk_done_o;
    logic        sk_err_o;
    logic        busy_o;
    logic        key_ready_o;

    modport slave (
        input  load_start_i, in_valid_i, in_word_i, sk_req_i, sk_idx_i,
`ifdef SKEIN_SUBKEY_AUTOINC_EN
        input  sk_next_i,
`endif
        output in_ready_o, sk_we_o, sk_word_o, sk_done_o, sk_err_o, busy_o, key_ready_o
    );

    modport master (
        output load_start_i, in_valid_i, in_word_i, sk_req_i, sk_idx_i,
`ifdef SKEIN_SUBKEY_AUTOINC_EN
        output sk_next_i,
`endif
        input  in_ready_o, sk_we_o, sk_word_o, sk_done_o, sk_err_o, busy_o, key_ready_o
    );

endinterface

// File: rtl/skein_subkey_scheduler_key_store.sv
// Extended key (17 words) and tweak (3 words) storage with combinational read ports.
// The derived-word port writes k16 or t2 in the same cycle as the last key or tweak beat.
module skein_key_store
    import skein_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        i_kwe,
    input  logic [4:0]  i_kwaddr,
    input  logic [63:0] i_kwdata,
    input  logic        i_twe,
    input  logic [1:0]  i_twaddr,
    input  logic [63:0] i_twdata,
    input  logic        i_dwe,
    input  logic        i_dsel,
    input  logic [63:0] i_ddata,
    input  logic [4:0]  i_krd_idx,
    output logic [63:0] o_krd_data,
    input  logic [1:0]  i_trd_idx,
    output logic [63:0] o_trd_data
);

    logic [63:0] r_key   [NUM_KEY_WORDS];
    logic [63:0] r_tweak [NUM_TWEAK_WORDS];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_key   <= '{default: '0};
            r_tweak <= '{default: '0};
        end else begin
            if (i_kwe)
                r_key[i_kwaddr] <= i_kwdata;
            if (i_dwe && !i_dsel)
                r_key[NUM_KEY_WORDS-1] <= i_ddata;
            if (i_twe)
                r_tweak[i_twaddr] <= i_twdata;
            if (i_dwe && i_dsel)
                r_tweak[NUM_TWEAK_WORDS-1] <= i_ddata;
        end
    end

    assign o_krd_data = r_key[i_krd_idx];
    assign o_trd_data = r_tweak[i_trd_idx];

endmodule

// File: rtl/skein_subkey_scheduler.sv
// Threefish-1024 key schedule: loads key/tweak, then emits subkey s word-serially to 16 registers.
// SKEIN_SUBKEY_AUTOINC_EN adds sk_next_i (generate previous subkey index + 1).
module skein_subkey_scheduler
    import skein_pkg::*;
(
    input logic                     clk_i,
    input logic                     rst_n_i,
    skein_subkey_scheduler_if.slave bus
);

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [63:0] r_x, w_x_nxt;
    logic [4:0]  r_s, w_s_nxt;
    logic [1:0]  r_smod3, w_smod3_nxt;
    logic        r_key_ready, w_key_ready_nxt;
    logic [15:0] r_sk_we, w_sk_we_nxt;
    logic [63:0] r_sk_word, w_sk_word_nxt;
    logic        r_sk_done, w_sk_done_nxt;
    logic        r_sk_err, w_sk_err_nxt;

    logic        w_in_ready;
    logic        w_key_beat, w_twk_beat;
    logic        w_start, w_req_err;
    logic [4:0]  w_start_idx;
    logic [4:0]  w_krd_idx;
    logic [1:0]  w_trd_idx;
    logic [63:0] w_krd_data, w_trd_data;
    logic [63:0] w_gen_word;
    logic        w_dwe, w_dsel;
    logic [63:0] w_ddata;

    assign w_in_ready = (r_state == ST_LOAD_KEY) || (r_state == ST_LOAD_TWEAK);
    assign w_key_beat = (r_state == ST_LOAD_KEY)   && bus.in_valid_i && !bus.load_start_i;
    assign w_twk_beat = (r_state == ST_LOAD_TWEAK) && bus.in_valid_i && !bus.load_start_i;

    // k16 and t2 are written alongside the final key / tweak beat
    assign w_dwe   = (w_key_beat && (r_cnt == 4'd15)) || (w_twk_beat && (r_cnt == 4'd1));
    assign w_dsel  = (r_state == ST_LOAD_TWEAK);
    assign w_ddata = w_dsel ? (w_trd_data ^ bus.in_word_i) : (r_x ^ bus.in_word_i);

    assign w_krd_idx = mod17_idx({1'b0, r_s} + {2'b00, r_cnt});

    always_comb begin
        w_trd_idx = 2'd0;
        if (r_state == ST_GEN)
            w_trd_idx = (r_cnt == 4'd13) ? TWEAK_LUT_LO[r_smod3] : TWEAK_LUT_HI[r_smod3];
    end

    always_comb begin
        w_gen_word = w_krd_data;
        case (r_cnt)
            4'd13, 4'd14: w_gen_word = w_krd_data + w_trd_data;
            4'd15:        w_gen_word = w_krd_data + {59'd0, r_s};
            default:      w_gen_word = w_krd_data;
        endcase
    end

    skein_key_store u_key_store (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .i_kwe      (w_key_beat),
        .i_kwaddr   ({1'b0, r_cnt}),
        .i_kwdata   (bus.in_word_i),
        .i_twe      (w_twk_beat),
        .i_twaddr   ({1'b0, r_cnt[0]}),
        .i_twdata   (bus.in_word_i),
        .i_dwe      (w_dwe),
        .i_dsel     (w_dsel),
        .i_ddata    (w_ddata),
        .i_krd_idx  (w_krd_idx),
        .o_krd_data (w_krd_data),
        .i_trd_idx  (w_trd_idx),
        .o_trd_data (w_trd_data)
    );

`ifdef SKEIN_SUBKEY_AUTOINC_EN
    logic [4:0] r_sprev;
    logic       r_sprev_vld;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_sprev     <= '0;
            r_sprev_vld <= 1'b0;
        end else if (bus.load_start_i) begin
            r_sprev     <= '0;
            r_sprev_vld <= 1'b0;
        end else if (w_start) begin
            r_sprev     <= w_start_idx;
            r_sprev_vld <= 1'b1;
        end
    end
`endif

    // Explicit sk_req_i has priority over the auto-increment request
    always_comb begin
        w_start     = 1'b0;
        w_req_err   = 1'b0;
        w_start_idx = '0;
        if ((r_state == ST_READY) && !bus.load_start_i) begin
            if (bus.sk_req_i) begin
                if (bus.sk_idx_i <= MAX_SUBKEY_IDX) begin
                    w_start     = 1'b1;
                    w_start_idx = bus.sk_idx_i;
                end else begin
                    w_req_err = 1'b1;
                end
            end
`ifdef SKEIN_SUBKEY_AUTOINC_EN
            else if (bus.sk_next_i) begin
                if (!r_sprev_vld) begin
                    w_start = 1'b1;
                end else if (r_sprev == MAX_SUBKEY_IDX) begin
                    w_req_err = 1'b1;
                end else begin
                    w_start     = 1'b1;
                    w_start_idx = r_sprev + 5'd1;
                end
            end
`endif
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_x_nxt         = r_x;
        w_s_nxt         = r_s;
        w_smod3_nxt     = r_smod3;
        w_key_ready_nxt = r_key_ready;
        w_sk_we_nxt     = '0;
        w_sk_word_nxt   = '0;
        w_sk_done_nxt   = 1'b0;
        w_sk_err_nxt    = 1'b0;
        if (bus.load_start_i) begin
            w_state_nxt     = ST_LOAD_KEY;
            w_cnt_nxt       = '0;
            w_x_nxt         = C240;
            w_key_ready_nxt = 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                end
                ST_LOAD_KEY: begin
                    if (bus.in_valid_i) begin
                        w_x_nxt   = r_x ^ bus.in_word_i;
                        w_cnt_nxt = r_cnt + 4'd1;
                        if (r_cnt == 4'd15) begin
                            w_state_nxt = ST_LOAD_TWEAK;
                            w_cnt_nxt   = '0;
                        end
                    end
                end
                ST_LOAD_TWEAK: begin
                    if (bus.in_valid_i) begin
                        w_cnt_nxt = r_cnt + 4'd1;
                        if (r_cnt == 4'd1) begin
                            w_state_nxt     = ST_READY;
                            w_cnt_nxt       = '0;
                            w_key_ready_nxt = 1'b1;
                        end
                    end
                end
                ST_READY: begin
                    w_sk_err_nxt = w_req_err;
                    if (w_start) begin
                        w_state_nxt = ST_GEN;
                        w_cnt_nxt   = '0;
                        w_s_nxt     = w_start_idx;
                        w_smod3_nxt = mod3_idx(w_start_idx);
                    end
                end
                ST_GEN: begin
                    w_sk_we_nxt   = 16'h0001 << r_cnt;
                    w_sk_word_nxt = w_gen_word;
                    w_cnt_nxt     = r_cnt + 4'd1;
                    if (r_cnt == 4'd15) begin
                        w_sk_done_nxt = 1'b1;
                        w_state_nxt   = ST_READY;
                        w_cnt_nxt     = '0;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_x         <= '0;
            r_s         <= '0;
            r_smod3     <= '0;
            r_key_ready <= 1'b0;
            r_sk_we     <= '0;
            r_sk_word   <= '0;
            r_sk_done   <= 1'b0;
            r_sk_err    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_x         <= w_x_nxt;
            r_s         <= w_s_nxt;
            r_smod3     <= w_smod3_nxt;
            r_key_ready <= w_key_ready_nxt;
            r_sk_we     <= w_sk_we_nxt;
            r_sk_word   <= w_sk_word_nxt;
            r_sk_done   <= w_sk_done_nxt;
            r_sk_err    <= w_sk_err_nxt;
        end
    end

    assign bus.in_ready_o  = w_in_ready;
    assign bus.busy_o      = (r_state != ST_READY) && (r_state != ST_IDLE);
    assign bus.key_ready_o = r_key_ready;
    assign bus.sk_we_o     = r_sk_we;
    assign bus.sk_word_o   = r_sk_word;
    assign bus.sk_done_o   = r_sk_done;
    assign bus.sk_err_o    = r_sk_err;

endmodule
